// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: walks every input vector of an N_IN-input gate, waits a settle
// interval, samples the gate output and compares the assembled table with a golden copy.
module truth_table_sweeper #(
  parameter int unsigned N_IN          = 3,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                abort,
  input  logic [(1 << N_IN)-1:0]              expected,
  output logic [N_IN-1:0]                     dut_in,
  input  logic                                dut_out,
  output logic                                busy,
  output logic                                done,
  output logic [(1 << N_IN)-1:0]              table_out,
  output logic                                pass,
  output logic [$clog2((1 << N_IN) + 1)-1:0]  mismatch_cnt
);

  localparam int unsigned TblW    = 1 << N_IN;
  localparam int unsigned CntBits = $clog2(TblW + 1);
  localparam int unsigned SetW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [SetW-1:0]    SetLast = SetW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [N_IN-1:0]    IdxLast = {N_IN{1'b1}};
  localparam logic [CntBits-1:0] CntMax  = CntBits'(TblW);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSettle = 2'd1;
  localparam logic [1:0] StSample = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;
  // With no settle interval every vector goes straight to its sample cycle.
  localparam logic [1:0] StVecEntry = (SETTLE_CYCLES == 0) ? StSample : StSettle;

  logic [1:0]         state_q, state_d;
  logic [N_IN-1:0]    idx_q, idx_d;
  logic [SetW-1:0]    set_q, set_d;
  logic [TblW-1:0]    gold_q, gold_d;
  logic [TblW-1:0]    table_q, table_d;
  logic [CntBits-1:0] mm_q, mm_d;
  logic               pass_q, pass_d;
  logic [CntBits-1:0] mm_next;

  // Next-state logic for the sweep FSM and its datapath registers.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    set_d   = set_q;
    gold_d  = gold_q;
    table_d = table_q;
    mm_d    = mm_q;
    pass_d  = pass_q;
    mm_next = mm_q;
    if ((dut_out != gold_q[idx_q]) && (mm_q != CntMax)) begin
      mm_next = mm_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          gold_d  = expected;
          table_d = '0;
          mm_d    = '0;
          pass_d  = 1'b0;
          idx_d   = '0;
          set_d   = '0;
          state_d = StVecEntry;
        end
      end
      StSettle: begin
        if (abort) begin
          state_d = StIdle;
          idx_d   = '0;
          set_d   = '0;
          pass_d  = 1'b0;
        end else if (set_q == SetLast) begin
          set_d   = '0;
          state_d = StSample;
        end else begin
          set_d = set_q + 1'b1;
        end
      end
      StSample: begin
        if (abort) begin
          // An aborted sample is dropped; partial table and count stay visible.
          state_d = StIdle;
          idx_d   = '0;
          set_d   = '0;
          pass_d  = 1'b0;
        end else begin
          table_d[idx_q] = dut_out;
          mm_d           = mm_next;
          if (idx_q == IdxLast) begin
            pass_d  = (mm_next == '0);
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StVecEntry;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      set_q   <= '0;
      gold_q  <= '0;
      table_q <= '0;
      mm_q    <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      set_q   <= set_d;
      gold_q  <= gold_d;
      table_q <= table_d;
      mm_q    <= mm_d;
      pass_q  <= pass_d;
    end
  end

  assign dut_in       = idx_q;
  assign busy         = (state_q != StIdle);
  assign done         = (state_q == StDone);
  assign table_out    = table_q;
  assign pass         = pass_q;
  assign mismatch_cnt = mm_q;

endmodule
